// File: rtl/jt49_stereo_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt49_stereo_if
//  Description : Bundle between the JT49 channel source and the stereo mixer.
//                The source drives the sample strobe, the mix mode and the
//                three unsigned 8-bit channel levels. The mixer returns the
//                10-bit left/right samples, a one-cycle valid strobe and busy.
//  Signals     : clk_en      sample strobe, one clk wide
//                mode[1:0]   00/11 mono, 01 ABC, 10 ACB
//                A/B/C[7:0]  channel levels, unsigned
//                left/right  10-bit unsigned outputs
//                valid       high for the cycle in which left/right update
//                busy        high while a mix/filter pass is in flight
//  Revision    : 1.0  initial release
// ============================================================================
interface jt49_stereo_if;
    logic       clk_en;
    logic [1:0] mode;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic [9:0] left;
    logic [9:0] right;
    logic       valid;
    logic       busy;

    modport master (
        output clk_en, mode, A, B, C,
        input  left, right, valid, busy
    );

    modport slave (
        input  clk_en, mode, A, B, C,
        output left, right, valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/jt49_stereo.sv
`default_nettype none
// ============================================================================
//  Module      : jt49_stereo
//  Description : Latches the three JT49 channel levels on a sample strobe,
//                forms a mono, ABC or ACB stereo mix, passes both sides
//                through a one-pole low-pass (acc += mix - acc>>SHIFT) and
//                presents registered left/right with a one-cycle valid.
//  Parameters  : SHIFT       low-pass exponent 0..6, 0 bypasses the filter
//  Ports       : clk         system clock, rising edge
//                rst         synchronous active-high reset
//                bus         jt49_stereo_if slave (strobe, mode, A/B/C in;
//                            left/right/valid/busy out)
//  Revision    : 1.0  initial release
// ============================================================================
module jt49_stereo #(
    parameter int SHIFT = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    jt49_stereo_if.slave bus
);

    localparam int c_ACC_W = 10 + SHIFT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUM  = 2'd1,
        S_FILT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_pending;
    logic   w_pending_next;
    logic   w_load;

    logic [7:0]         r_a, r_b, r_c;
    logic [1:0]         r_m;
    logic [9:0]         w_mix_l, w_mix_r;
    logic [9:0]         r_mix_l, r_mix_r;
    logic [c_ACC_W-1:0] r_acc_l, r_acc_r;
    logic [c_ACC_W-1:0] w_acc_l_next, w_acc_r_next;
    logic [9:0]         r_left, r_right;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pending_next = 1'b0;
                if (bus.clk_en) begin
                    w_load       = 1'b1;
                    w_state_next = S_SUM;
                end
            end
            S_SUM: begin
                w_state_next = S_FILT;
                // One-deep: a second strobe while pending is already set
                // simply leaves the flag set, i.e. it is dropped.
                if (bus.clk_en) w_pending_next = 1'b1;
            end
            S_FILT: begin
                w_state_next = S_OUT;
                if (bus.clk_en) w_pending_next = 1'b1;
            end
            S_OUT: begin
                // A strobe arriving in OUT itself is handled like a pending
                // one; with pending already set such a strobe is dropped.
                w_pending_next = 1'b0;
                if (r_pending || bus.clk_en) begin
                    w_load       = 1'b1;
                    w_state_next = S_SUM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_pending_next = 1'b0;
            end
        endcase
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.valid = (r_state == S_OUT);

    // ------------------------------------------------------------------
    // Input latches: a pending pass captures the channels at the edge it
    // actually starts, not at the edge its strobe arrived.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= 8'd0;
            r_b <= 8'd0;
            r_c <= 8'd0;
            r_m <= 2'd0;
        end else if (w_load) begin
            r_a <= bus.A;
            r_b <= bus.B;
            r_c <= bus.C;
            r_m <= bus.mode;
        end
    end

    // ------------------------------------------------------------------
    // Mixer (max 765, fits 10 bits)
    // ------------------------------------------------------------------
    always_comb begin
        w_mix_l = 10'd0;
        w_mix_r = 10'd0;
        case (r_m)
            2'b01: begin
                w_mix_l = {1'b0, r_a, 1'b0} + {2'b00, r_b};
                w_mix_r = {1'b0, r_c, 1'b0} + {2'b00, r_b};
            end
            2'b10: begin
                w_mix_l = {1'b0, r_a, 1'b0} + {2'b00, r_c};
                w_mix_r = {1'b0, r_b, 1'b0} + {2'b00, r_c};
            end
            default: begin
                w_mix_l = {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c};
                w_mix_r = w_mix_l;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix_l <= 10'd0;
            r_mix_r <= 10'd0;
        end else if (r_state == S_SUM) begin
            r_mix_l <= w_mix_l;
            r_mix_r <= w_mix_r;
        end
    end

    // ------------------------------------------------------------------
    // One-pole low-pass. acc - (acc >> SHIFT) never underflows and the
    // accumulator settles at mix << SHIFT, so c_ACC_W bits never overflow.
    // The output register takes the new accumulator on the edge entering
    // OUT so data and valid line up.
    // ------------------------------------------------------------------
    assign w_acc_l_next = r_acc_l - (r_acc_l >> SHIFT) + c_ACC_W'(r_mix_l);
    assign w_acc_r_next = r_acc_r - (r_acc_r >> SHIFT) + c_ACC_W'(r_mix_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_left  <= 10'd0;
            r_right <= 10'd0;
        end else if (r_state == S_FILT) begin
            r_acc_l <= w_acc_l_next;
            r_acc_r <= w_acc_r_next;
            r_left  <= w_acc_l_next[c_ACC_W-1:SHIFT];
            r_right <= w_acc_r_next[c_ACC_W-1:SHIFT];
        end
    end

    assign bus.left  = r_left;
    assign bus.right = r_right;

endmodule
`default_nettype wire

// File: tb/tb_jt49_stereo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt49_stereo
//  Description : Self-checking bench. Two mixers (SHIFT=0 and SHIFT=2) see
//                the same stimulus; expected left/right pairs are queued when
//                a pass is launched and popped whenever a mixer raises valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jt49_stereo;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [1:0] mode;
    logic [7:0] A, B, C;

    int n_pass;
    int n_total;

    logic [19:0] q0[$];
    logic [19:0] q2[$];
    int          m_acc_l;
    int          m_acc_r;

    jt49_stereo_if bus0 ();
    jt49_stereo_if bus2 ();

    assign bus0.clk_en = clk_en;
    assign bus0.mode   = mode;
    assign bus0.A      = A;
    assign bus0.B      = B;
    assign bus0.C      = C;
    assign bus2.clk_en = clk_en;
    assign bus2.mode   = mode;
    assign bus2.A      = A;
    assign bus2.B      = B;
    assign bus2.C      = C;

    jt49_stereo #(.SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    jt49_stereo #(.SHIFT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [19:0] mix_of(input logic [1:0] md,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
        int l;
        int r;
        case (md)
            2'b01:   begin l = 2 * a + b; r = 2 * c + b; end
            2'b10:   begin l = 2 * a + c; r = 2 * b + c; end
            default: begin l = a + b + c; r = l;         end
        endcase
        return {10'(l), 10'(r)};
    endfunction

    task automatic push_pass(input logic [1:0] md, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] c);
        logic [19:0] mx;
        int          ml;
        int          mr;
        mx = mix_of(md, a, b, c);
        ml = int'(mx[19:10]);
        mr = int'(mx[9:0]);
        q0.push_back(mx);
        m_acc_l = m_acc_l + ml - (m_acc_l >> 2);
        m_acc_r = m_acc_r + mr - (m_acc_r >> 2);
        q2.push_back({10'(m_acc_l >> 2), 10'(m_acc_r >> 2)});
    endtask

    task automatic model_reset();
        m_acc_l = 0;
        m_acc_r = 0;
        q0.delete();
        q2.delete();
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (bus0.valid === 1'b1) begin
            n_total++;
            if (q0.size() == 0) begin
                $display("FAIL sb_shift0: valid with no pass expected, got %0d/%0d",
                         bus0.left, bus0.right);
            end else begin
                logic [19:0] e;
                e = q0.pop_front();
                if ({bus0.left, bus0.right} !== e)
                    $display("FAIL sb_shift0: got L=%0d R=%0d expected L=%0d R=%0d",
                             bus0.left, bus0.right, e[19:10], e[9:0]);
                else
                    n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.valid === 1'b1) begin
            n_total++;
            if (q2.size() == 0) begin
                $display("FAIL sb_shift2: valid with no pass expected, got %0d/%0d",
                         bus2.left, bus2.right);
            end else begin
                logic [19:0] e;
                e = q2.pop_front();
                if ({bus2.left, bus2.right} !== e)
                    $display("FAIL sb_shift2: got L=%0d R=%0d expected L=%0d R=%0d",
                             bus2.left, bus2.right, e[19:10], e[9:0]);
                else
                    n_pass++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse(input logic [1:0] md, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        mode   = md;
        A      = a;
        B      = b;
        C      = c;
        clk_en = 1'b1;
        @(posedge clk);
        #1 clk_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total += 4;
        if (bus0.left !== 10'd0 || bus0.right !== 10'd0)
            $display("FAIL reset_data0: got %0d/%0d expected 0/0", bus0.left, bus0.right);
        else n_pass++;
        if (bus0.valid !== 1'b0 || bus0.busy !== 1'b0)
            $display("FAIL reset_ctrl0: valid=%b busy=%b expected 0/0", bus0.valid, bus0.busy);
        else n_pass++;
        if (bus2.left !== 10'd0 || bus2.right !== 10'd0)
            $display("FAIL reset_data2: got %0d/%0d expected 0/0", bus2.left, bus2.right);
        else n_pass++;
        if (bus2.valid !== 1'b0 || bus2.busy !== 1'b0)
            $display("FAIL reset_ctrl2: valid=%b busy=%b expected 0/0", bus2.valid, bus2.busy);
        else n_pass++;
    endtask

    task automatic test_single();
        push_pass(2'b01, 8'd255, 8'd0, 8'd0);
        pulse(2'b01, 8'd255, 8'd0, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_total += 2;
            if (bus0.valid !== (k == 3))
                $display("FAIL single_valid k=%0d: got %b expected %b", k, bus0.valid, (k == 3));
            else n_pass++;
            if (bus0.busy !== (k <= 3))
                $display("FAIL single_busy k=%0d: got %b expected %b", k, bus0.busy, (k <= 3));
            else n_pass++;
        end
    endtask

    task automatic test_mono();
        push_pass(2'b00, 8'd255, 8'd255, 8'd255);
        pulse(2'b00, 8'd255, 8'd255, 8'd255);
        repeat (4) @(posedge clk);
        push_pass(2'b11, 8'd255, 8'd255, 8'd255);
        pulse(2'b11, 8'd255, 8'd255, 8'd255);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_stereo();
        push_pass(2'b10, 8'd10, 8'd20, 8'd30);
        pulse(2'b10, 8'd10, 8'd20, 8'd30);
        repeat (4) @(posedge clk);
        push_pass(2'b01, 8'd10, 8'd20, 8'd30);
        pulse(2'b01, 8'd10, 8'd20, 8'd30);
        repeat (4) @(posedge clk);
    endtask

    // Strobes every third cycle: each one must produce its own pass.
    task automatic test_filter();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            push_pass(2'b01, 8'd200, 8'd0, 8'd0);
            pulse(2'b01, 8'd200, 8'd0, 8'd0);
            @(posedge clk);
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        push_pass(2'b01, 8'd10, 8'd20, 8'd30);
        push_pass(2'b10, 8'd1, 8'd2, 8'd3);
        @(negedge clk);
        mode   = 2'b01;
        A      = 8'd10;
        B      = 8'd20;
        C      = 8'd30;
        clk_en = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_total++;
            if (bus0.valid !== (k == 3 || k == 6))
                $display("FAIL b2b_valid k=%0d: got %b expected %b",
                         k, bus0.valid, (k == 3 || k == 6));
            else n_pass++;
            if (k == 2) begin
                mode = 2'b10;
                A    = 8'd1;
                B    = 8'd2;
                C    = 8'd3;
            end else if (k == 3) begin
                clk_en = 1'b0;
            end else if (k == 4) begin
                A = 8'd99;
                B = 8'd99;
                C = 8'd99;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pulse(2'b01, 8'd255, 8'd0, 8'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_total += 3;
        if (bus0.left !== 10'd0 || bus0.right !== 10'd0)
            $display("FAIL midrst_data: got %0d/%0d expected 0/0", bus0.left, bus0.right);
        else n_pass++;
        if (bus0.busy !== 1'b0 || bus2.busy !== 1'b0)
            $display("FAIL midrst_busy: got %b/%b expected 0/0", bus0.busy, bus2.busy);
        else n_pass++;
        if (bus2.left !== 10'd0 || bus2.valid !== 1'b0)
            $display("FAIL midrst_data2: left=%0d valid=%b expected 0/0", bus2.left, bus2.valid);
        else n_pass++;
        repeat (4) @(negedge clk);
        push_pass(2'b01, 8'd255, 8'd0, 8'd0);
        pulse(2'b01, 8'd255, 8'd0, 8'd0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus2.valid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen)
            $display("FAIL midrst_fresh: timeout waiting for valid, expected left 127");
        else if (bus2.left !== 10'd127)
            $display("FAIL midrst_fresh: got left %0d expected 127", bus2.left);
        else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_drain();
        repeat (4) @(negedge clk);
        n_total++;
        if (q0.size() != 0 || q2.size() != 0)
            $display("FAIL drain: %0d/%0d expected passes never appeared, required 0/0",
                     q0.size(), q2.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_acc_l = 0;
        m_acc_r = 0;
        rst     = 1'b1;
        clk_en  = 1'b0;
        mode    = 2'b00;
        A       = 8'd0;
        B       = 8'd0;
        C       = 8'd0;
        test_reset();
        test_single();
        test_mono();
        test_stereo();
        test_back_to_back();
        test_filter();
        test_reset_mid();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
